// File: rtl/traffic_light_monitor_if.sv
// Lamp bus between the traffic-light controller and anything observing it.
// Latency: none, plain wires.
// Backpressure: none; the bus is broadcast and only the controller drives it.
interface traffic_light_monitor_if;
    // one-hot lamps: [2]=red, [1]=yellow, [0]=green
    logic [2:0] light;

    modport master (output light);
    modport slave  (input  light);
endinterface

// File: rtl/traffic_light_monitor.sv
// Passive checker of the lamp sequence, dwell times and encoding, plus a light-cycle counter.
// Latency: 1 clock from a lamp sample to phase/dwell/error outputs (all outputs registered).
// Backpressure: none; the monitor only listens and never stalls or drives the lamp bus.
module traffic_light_monitor #(
    parameter int RED_CYCLES    = 5,
    parameter int GREEN_CYCLES  = 4,
    parameter int YELLOW_CYCLES = 2,
    parameter int CNT_W         = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    traffic_light_monitor_if.slave       bus,
    output logic                         locked,
    output logic [1:0]                   phase,
    output logic [CNT_W-1:0]             dwell,
    output logic                         err_pulse,
    output logic                         err_illegal,
    output logic                         err_seq,
    output logic                         err_short,
    output logic                         err_long,
    output logic [15:0]                  cycle_count
);

    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b001;

    localparam logic [1:0] PH_NONE   = 2'd0;
    localparam logic [1:0] PH_RED    = 2'd1;
    localparam logic [1:0] PH_GREEN  = 2'd2;
    localparam logic [1:0] PH_YELLOW = 2'd3;

    localparam logic [CNT_W-1:0] REQ_RED    = CNT_W'(RED_CYCLES);
    localparam logic [CNT_W-1:0] REQ_GREEN  = CNT_W'(GREEN_CYCLES);
    localparam logic [CNT_W-1:0] REQ_YELLOW = CNT_W'(YELLOW_CYCLES);
    localparam logic [CNT_W-1:0] DWELL_MAX  = {CNT_W{1'b1}};

    typedef enum logic {
        UNSYNC = 1'b0,
        TRACK  = 1'b1
    } state_t;

    function automatic logic is_legal(input logic [2:0] code);
        return (code == LAMP_RED) || (code == LAMP_GREEN) || (code == LAMP_YELLOW);
    endfunction

    // Successor in RED -> GREEN -> YELLOW -> RED; illegal codes map to 000 (never matches).
    function automatic logic [2:0] successor(input logic [2:0] code);
        case (code)
            LAMP_RED:    return LAMP_GREEN;
            LAMP_GREEN:  return LAMP_YELLOW;
            LAMP_YELLOW: return LAMP_RED;
            default:     return 3'b000;
        endcase
    endfunction

    function automatic logic [1:0] phase_of(input logic [2:0] code);
        case (code)
            LAMP_RED:    return PH_RED;
            LAMP_GREEN:  return PH_GREEN;
            LAMP_YELLOW: return PH_YELLOW;
            default:     return PH_NONE;
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] required(input logic [2:0] code);
        case (code)
            LAMP_RED:    return REQ_RED;
            LAMP_GREEN:  return REQ_GREEN;
            LAMP_YELLOW: return REQ_YELLOW;
            default:     return '0;
        endcase
    endfunction

    logic [2:0]       light;
    logic [2:0]       prev;
    state_t           state;
    state_t           state_d;
    logic [1:0]       phase_d;
    logic [CNT_W-1:0] dwell_d;
    logic [15:0]      cycle_d;
    logic             hit_illegal;
    logic             hit_seq;
    logic             hit_short;
    logic             hit_long;

    assign light = bus.light;

    // State, previous sample and all registered outputs; sticky flags only clear on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= UNSYNC;
            prev        <= 3'b000;
            locked      <= 1'b0;
            phase       <= PH_NONE;
            dwell       <= '0;
            err_pulse   <= 1'b0;
            err_illegal <= 1'b0;
            err_seq     <= 1'b0;
            err_short   <= 1'b0;
            err_long    <= 1'b0;
            cycle_count <= 16'd0;
        end else begin
            state       <= state_d;
            prev        <= light;
            locked      <= (state_d == TRACK);
            phase       <= phase_d;
            dwell       <= dwell_d;
            err_pulse   <= hit_illegal | hit_seq | hit_short | hit_long;
            err_illegal <= err_illegal | hit_illegal;
            err_seq     <= err_seq | hit_seq;
            err_short   <= err_short | hit_short;
            err_long    <= err_long | hit_long;
            cycle_count <= cycle_d;
        end
    end

    // Next state, dwell/phase tracking and violation detection; in TRACK, prev is the tracked phase.
    always_comb begin
        state_d     = state;
        phase_d     = phase;
        dwell_d     = dwell;
        cycle_d     = cycle_count;
        hit_illegal = 1'b0;
        hit_seq     = 1'b0;
        hit_short   = 1'b0;
        hit_long    = 1'b0;

        if (!is_legal(light)) begin
            // Bad encoding drops lock from either state; the abandoned phase is not timed.
            hit_illegal = 1'b1;
            state_d     = UNSYNC;
            phase_d     = PH_NONE;
            dwell_d     = '0;
        end else if (state == UNSYNC) begin
            // Lock only on an observed legal transition, so the first phase is never timed.
            if (is_legal(prev) && (light == successor(prev))) begin
                state_d = TRACK;
                phase_d = phase_of(light);
                dwell_d = CNT_W'(1);
            end else begin
                phase_d = PH_NONE;
                dwell_d = '0;
            end
        end else if (light == prev) begin
            // Same phase continues; overrun flagged once, on the cycle dwell reaches required+1.
            if (dwell != DWELL_MAX) begin
                dwell_d = dwell + CNT_W'(1);
                if (dwell == required(prev)) begin
                    hit_long = 1'b1;
                end
            end
        end else if (light == successor(prev)) begin
            // Orderly advance: judge the old phase, start the new one.
            if (dwell < required(prev)) begin
                hit_short = 1'b1;
            end
            phase_d = phase_of(light);
            dwell_d = CNT_W'(1);
            if ((prev == LAMP_YELLOW) && (cycle_count != 16'hFFFF)) begin
                cycle_d = cycle_count + 16'd1;
            end
        end else begin
            // Legal code out of order: lose lock without judging the abandoned phase.
            hit_seq = 1'b1;
            state_d = UNSYNC;
            phase_d = PH_NONE;
            dwell_d = '0;
        end
    end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed-step bench for traffic_light_monitor with hand-computed expectations.
// Latency: each step drives one lamp sample and checks outputs 1 ns after the capturing edge.
// Backpressure: none; the bench drives the lamp bus freely every clock.
module tb_traffic_light_monitor;

    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] GREEN  = 3'b001;

    logic        clk;
    logic        reset;
    logic        locked;
    logic [1:0]  phase;
    logic [7:0]  dwell;
    logic        err_pulse;
    logic        err_illegal;
    logic        err_seq;
    logic        err_short;
    logic        err_long;
    logic [15:0] cycle_count;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    traffic_light_monitor_if bus ();

    traffic_light_monitor #(
        .RED_CYCLES   (5),
        .GREEN_CYCLES (4),
        .YELLOW_CYCLES(2),
        .CNT_W        (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .locked     (locked),
        .phase      (phase),
        .dwell      (dwell),
        .err_pulse  (err_pulse),
        .err_illegal(err_illegal),
        .err_seq    (err_seq),
        .err_short  (err_short),
        .err_long   (err_long),
        .cycle_count(cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input string field, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s.%s: observed %0h expected %0h", tag, field, obs, exp);
        end
    endtask

    // flags = {err_illegal, err_seq, err_short, err_long}
    task automatic expect_st(input string tag, input logic lk, input logic [1:0] ph, input logic [7:0] dw,
                             input logic pl, input logic [3:0] flags, input logic [15:0] cc);
        chk(tag, "locked",      32'(locked),      32'(lk));
        chk(tag, "phase",       32'(phase),       32'(ph));
        chk(tag, "dwell",       32'(dwell),       32'(dw));
        chk(tag, "err_pulse",   32'(err_pulse),   32'(pl));
        chk(tag, "flags",       32'({err_illegal, err_seq, err_short, err_long}), 32'(flags));
        chk(tag, "cycle_count", 32'(cycle_count), 32'(cc));
    endtask

    task automatic step(input logic [2:0] l);
        bus.light = l;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        bus.light = RED;
        step(RED);
        step(RED);
        expect_st("reset", 1'b0, 2'd0, 8'd0, 1'b0, 4'b0000, 16'd0);
        reset = 1'b0;

        // Clean sequence: first red is untimed, lock on first green
        for (int i = 1; i <= 3; i++) begin step(RED);    expect_st("clean_red0",   1'b0, 2'd0, 8'd0,    1'b0, 4'b0000, 16'd0); end
        for (int i = 1; i <= 4; i++) begin step(GREEN);  expect_st("clean_green1", 1'b1, 2'd2, 8'(i),   1'b0, 4'b0000, 16'd0); end
        for (int i = 1; i <= 2; i++) begin step(YELLOW); expect_st("clean_yel1",   1'b1, 2'd3, 8'(i),   1'b0, 4'b0000, 16'd0); end
        for (int i = 1; i <= 5; i++) begin step(RED);    expect_st("clean_red1",   1'b1, 2'd1, 8'(i),   1'b0, 4'b0000, 16'd1); end
        for (int i = 1; i <= 4; i++) begin step(GREEN);  expect_st("clean_green2", 1'b1, 2'd2, 8'(i),   1'b0, 4'b0000, 16'd1); end
        for (int i = 1; i <= 2; i++) begin step(YELLOW); expect_st("clean_yel2",   1'b1, 2'd3, 8'(i),   1'b0, 4'b0000, 16'd1); end
        for (int i = 1; i <= 5; i++) begin step(RED);    expect_st("clean_red2",   1'b1, 2'd1, 8'(i),   1'b0, 4'b0000, 16'd2); end

        // Short green (3 < 4)
        for (int i = 1; i <= 3; i++) begin step(GREEN);  expect_st("short_green",  1'b1, 2'd2, 8'(i),   1'b0, 4'b0000, 16'd2); end
        step(YELLOW); expect_st("short_hit",  1'b1, 2'd3, 8'd1, 1'b1, 4'b0010, 16'd2);

        // Long yellow: overrun on third sample, single pulse
        step(YELLOW); expect_st("long_y2",    1'b1, 2'd3, 8'd2, 1'b0, 4'b0010, 16'd2);
        step(YELLOW); expect_st("long_y3",    1'b1, 2'd3, 8'd3, 1'b1, 4'b0011, 16'd2);
        step(YELLOW); expect_st("long_y4",    1'b1, 2'd3, 8'd4, 1'b0, 4'b0011, 16'd2);

        // Sequence error: green (dwell 4) straight to red
        for (int i = 1; i <= 5; i++) begin step(RED);    expect_st("seq_red",   1'b1, 2'd1, 8'(i), 1'b0, 4'b0011, 16'd3); end
        for (int i = 1; i <= 4; i++) begin step(GREEN);  expect_st("seq_green", 1'b1, 2'd2, 8'(i), 1'b0, 4'b0011, 16'd3); end
        step(RED);   expect_st("seq_hit",     1'b0, 2'd0, 8'd0, 1'b1, 4'b0111, 16'd3);
        step(RED);   expect_st("seq_unsync",  1'b0, 2'd0, 8'd0, 1'b0, 4'b0111, 16'd3);
        step(GREEN); expect_st("seq_relock",  1'b1, 2'd2, 8'd1, 1'b0, 4'b0111, 16'd3);

        // Illegal encoding while locked
        step(3'b011); expect_st("ill_hit",    1'b0, 2'd0, 8'd0, 1'b1, 4'b1111, 16'd3);
        step(RED);    expect_st("ill_unsync", 1'b0, 2'd0, 8'd0, 1'b0, 4'b1111, 16'd3);
        step(GREEN);  expect_st("ill_relock", 1'b1, 2'd2, 8'd1, 1'b0, 4'b1111, 16'd3);

        // Reset mid-green discards everything; continuing green is untimed
        step(GREEN);  expect_st("pre_reset",  1'b1, 2'd2, 8'd2, 1'b0, 4'b1111, 16'd3);
        reset = 1'b1;
        step(GREEN);  expect_st("mid_reset",  1'b0, 2'd0, 8'd0, 1'b0, 4'b0000, 16'd0);
        reset = 1'b0;
        for (int i = 1; i <= 3; i++) begin step(GREEN); expect_st("post_reset_green", 1'b0, 2'd0, 8'd0, 1'b0, 4'b0000, 16'd0); end
        step(YELLOW); expect_st("post_reset_lock", 1'b1, 2'd3, 8'd1, 1'b0, 4'b0000, 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
